// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared states, ALU control codes and opcodes for the core sequencer
package core_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'd0,
        ST_DECODE    = 3'd1,
        ST_EXECUTE   = 3'd2,
        ST_WRITEBACK = 3'd3,
        ST_HALT      = 3'd4
    } seq_state_e;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SLL = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_MUL = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_HCF = 4'b1001;

    localparam logic [6:0] OPCODE_RTYPE = 7'b0110011;

endpackage

// File: rtl/core_seq_mul_timer.sv
// rtl/core_seq_mul_timer.sv - loadable down-counter timing the extra EXECUTE cycles of MUL
module core_seq_mul_timer #(
    parameter int CNT_W = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_val,
    output logic             last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // load has priority; decrement saturates at zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (dec && (cnt_q != '0)) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // counter register, cleared by reset
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // the cycle that counts down to zero is the final MUL cycle
    assign last_o = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/core_sequencer.sv
// rtl/core_sequencer.sv - FETCH/DECODE/EXECUTE/WRITEBACK sequencer; CORE_SEQ_CYCLE_COUNT_EN adds cycle_count
module core_sequencer
    import core_pkg::*;
#(
    parameter int MUL_LATENCY = 3,
    parameter int RETIRE_W    = 32
) (
    input  logic                clock,
    input  logic                reset,
    output logic                imem_req,
    input  logic                imem_valid,
    input  logic [31:0]         imem_rdata,
    output logic [6:0]          opcode,
    output logic [2:0]          funct3,
    output logic [6:0]          funct7,
    input  logic [3:0]          alu_control,
    input  logic                regwrite_control,
    output logic                alu_start,
    output logic                rf_write_en,
    output logic                pc_advance,
    output logic                halted,
    output logic [RETIRE_W-1:0] retired,
    output logic [2:0]          state_o
`ifdef CORE_SEQ_CYCLE_COUNT_EN
    ,
    output logic [RETIRE_W-1:0] cycle_count
`endif
);

    localparam int CNT_W = (MUL_LATENCY > 1) ? $clog2(MUL_LATENCY) : 1;

    seq_state_e          state_q, state_d;
    logic [31:0]         instr_q, instr_d;
    logic [3:0]          op_q, op_d;
    logic                wr_q, wr_d;
    logic                first_q, first_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic [3:0]          exec_op;
    logic                mul_load;
    logic                mul_dec;
    logic                mul_last;

    // in the first EXECUTE cycle the op is taken live; afterwards from its register
    assign exec_op = first_q ? alu_control : op_q;

    core_seq_mul_timer #(
        .CNT_W(CNT_W)
    ) u_mul_timer (
        .clock    (clock),
        .reset    (reset),
        .load     (mul_load),
        .dec      (mul_dec),
        .load_val (CNT_W'(MUL_LATENCY - 1)),
        .last_o   (mul_last)
    );

    // next-state and strobe logic; strobes are forced low while reset is asserted
    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        op_d        = op_q;
        wr_d        = wr_q;
        first_d     = 1'b0;
        retired_d   = retired_q;
        mul_load    = 1'b0;
        mul_dec     = 1'b0;
        imem_req    = 1'b0;
        alu_start   = 1'b0;
        rf_write_en = 1'b0;
        pc_advance  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_valid) begin
                    instr_d = imem_rdata;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                first_d = 1'b1;
                state_d = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                if (first_q) begin
                    alu_start = 1'b1;
                    op_d      = alu_control;
                    wr_d      = regwrite_control;
                end
                if (exec_op == ALU_HCF) begin
                    retired_d = retired_q + RETIRE_W'(1);
                    state_d   = ST_HALT;
                end else if (exec_op == ALU_MUL) begin
                    if (first_q) begin
                        mul_load = 1'b1;
                        if (MUL_LATENCY == 1) begin
                            state_d = ST_WRITEBACK;
                        end
                    end else begin
                        mul_dec = 1'b1;
                        if (mul_last) begin
                            state_d = ST_WRITEBACK;
                        end
                    end
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                rf_write_en = wr_q;
                pc_advance  = 1'b1;
                retired_d   = retired_q + RETIRE_W'(1);
                state_d     = ST_FETCH;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_FETCH;
            end
        endcase
        if (reset) begin
            imem_req    = 1'b0;
            alu_start   = 1'b0;
            rf_write_en = 1'b0;
            pc_advance  = 1'b0;
        end
    end

    // sequencer registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= ST_FETCH;
            instr_q   <= '0;
            op_q      <= '0;
            wr_q      <= 1'b0;
            first_q   <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            instr_q   <= instr_d;
            op_q      <= op_d;
            wr_q      <= wr_d;
            first_q   <= first_d;
            retired_q <= retired_d;
        end
    end

    assign opcode  = instr_q[6:0];
    assign funct3  = instr_q[14:12];
    assign funct7  = instr_q[31:25];
    assign halted  = (state_q == ST_HALT);
    assign retired = retired_q;
    assign state_o = state_q;

`ifdef CORE_SEQ_CYCLE_COUNT_EN
    logic [RETIRE_W-1:0] cc_q, cc_d;

    // free-running cycle counter that freezes once halted
    always_comb begin
        cc_d = cc_q;
        if (state_q != ST_HALT) begin
            cc_d = cc_q + RETIRE_W'(1);
        end
    end

    // cycle counter register
    always_ff @(posedge clock) begin
        if (reset) begin
            cc_q <= '0;
        end else begin
            cc_q <= cc_d;
        end
    end

    assign cycle_count = cc_q;
`endif

endmodule

// File: tb/tb_core_sequencer.sv
// tb/tb_core_sequencer.sv - self-checking bench for core_sequencer (MUL_LATENCY 3 and 1 instances)
module tb_core_sequencer;
    import core_pkg::*;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic            reset;
    logic [1:0]      imem_valid_v, regw_v;
    logic [1:0]      imem_req_v, alu_start_v, rf_we_v, pc_adv_v, halted_v;
    logic [1:0][31:0] rdata_v, retired_v;
    logic [1:0][3:0] aluc_v;
    logic [1:0][6:0] opcode_v, funct7_v;
    logic [1:0][2:0] funct3_v, state_v;
`ifdef CORE_SEQ_CYCLE_COUNT_EN
    logic [1:0][31:0] cc_v;
`endif

    core_sequencer #(.MUL_LATENCY(3), .RETIRE_W(32)) u_dut3 (
        .clock(clock), .reset(reset),
        .imem_req(imem_req_v[0]), .imem_valid(imem_valid_v[0]), .imem_rdata(rdata_v[0]),
        .opcode(opcode_v[0]), .funct3(funct3_v[0]), .funct7(funct7_v[0]),
        .alu_control(aluc_v[0]), .regwrite_control(regw_v[0]),
        .alu_start(alu_start_v[0]), .rf_write_en(rf_we_v[0]), .pc_advance(pc_adv_v[0]),
        .halted(halted_v[0]), .retired(retired_v[0]), .state_o(state_v[0])
`ifdef CORE_SEQ_CYCLE_COUNT_EN
        , .cycle_count(cc_v[0])
`endif
    );

    core_sequencer #(.MUL_LATENCY(1), .RETIRE_W(32)) u_dut1 (
        .clock(clock), .reset(reset),
        .imem_req(imem_req_v[1]), .imem_valid(imem_valid_v[1]), .imem_rdata(rdata_v[1]),
        .opcode(opcode_v[1]), .funct3(funct3_v[1]), .funct7(funct7_v[1]),
        .alu_control(aluc_v[1]), .regwrite_control(regw_v[1]),
        .alu_start(alu_start_v[1]), .rf_write_en(rf_we_v[1]), .pc_advance(pc_adv_v[1]),
        .halted(halted_v[1]), .retired(retired_v[1]), .state_o(state_v[1])
`ifdef CORE_SEQ_CYCLE_COUNT_EN
        , .cycle_count(cc_v[1])
`endif
    );

    int total = 0;
    int bad   = 0;
    int exp_ret [2];
    int exp_cc;

    typedef struct {
        int          dut;
        logic [31:0] ins;
        logic [3:0]  ac;
        logic        rw;
        int          waits;
        int          ex;
        logic        we;
    } vec_t;

    vec_t tbl [9];
    logic [3:0] ops [7];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // one clock cycle on instance d: drive inputs, then check every output at the falling edge
    task automatic cyc(input int d, input logic v, input logic [31:0] rd, input logic [3:0] ac,
                       input logic rw, input logic [2:0] es, input logic ereq, input logic est,
                       input logic ewe, input logic epc, input logic eh);
        @(posedge clock);
        #1;
        reset           = 1'b0;
        imem_valid_v[d] = v;
        rdata_v[d]      = rd;
        aluc_v[d]       = ac;
        regw_v[d]       = rw;
        @(negedge clock);
        chk("state_o",     32'(state_v[d]),     32'(es));
        chk("imem_req",    32'(imem_req_v[d]),  32'(ereq));
        chk("alu_start",   32'(alu_start_v[d]), 32'(est));
        chk("rf_write_en", 32'(rf_we_v[d]),     32'(ewe));
        chk("pc_advance",  32'(pc_adv_v[d]),    32'(epc));
        chk("halted",      32'(halted_v[d]),    32'(eh));
        chk("retired",     retired_v[d],        32'(exp_ret[d]));
`ifdef CORE_SEQ_CYCLE_COUNT_EN
        if (d == 0) begin
            chk("cycle_count", cc_v[0], 32'(exp_cc));
            if (es != ST_HALT) exp_cc++;
        end
`endif
    endtask

    task automatic chk_fields(input int d, input logic [31:0] ins);
        chk("opcode", 32'(opcode_v[d]), 32'(ins[6:0]));
        chk("funct3", 32'(funct3_v[d]), 32'(ins[14:12]));
        chk("funct7", 32'(funct7_v[d]), 32'(ins[31:25]));
    endtask

    // one reset cycle; strobes must be low while reset is high
    task automatic reset_cycle(input logic chk_st, input logic [2:0] es);
        @(posedge clock);
        #1;
        reset        = 1'b1;
        imem_valid_v = '0;
        @(negedge clock);
        if (chk_st) chk("state_in_reset", 32'(state_v[0]), 32'(es));
        chk("req_in_reset",   32'(imem_req_v[0]),  32'd0);
        chk("start_in_reset", 32'(alu_start_v[0]), 32'd0);
        chk("we_in_reset",    32'(rf_we_v[0]),     32'd0);
        chk("pc_in_reset",    32'(pc_adv_v[0]),    32'd0);
        exp_ret[0] = 0;
        exp_ret[1] = 0;
        exp_cc     = 0;
    endtask

    // one full instruction: waits, fetch, decode, ex EXECUTE cycles, writeback (or halt)
    task automatic run_instr(input int d, input logic [31:0] ins, input logic [3:0] ac, input logic rw,
                             input int waits, input int ex, input logic ewe);
        for (int w = 0; w < waits; w++)
            cyc(d, 1'b0, 32'($urandom), 4'($urandom), 1'($urandom), ST_FETCH, 1, 0, 0, 0, 0);
        cyc(d, 1'b1, ins, 4'($urandom), 1'($urandom), ST_FETCH, 1, 0, 0, 0, 0);
        cyc(d, 1'b1, ~ins, ac, rw, ST_DECODE, 0, 0, 0, 0, 0);
        chk_fields(d, ins);
        cyc(d, 1'b0, 32'($urandom), ac, rw, ST_EXECUTE, 0, 1, 0, 0, 0);
        if (ac == ALU_HCF) begin
            exp_ret[d]++;
            return;
        end
        for (int k = 1; k < ex; k++)
            cyc(d, 1'b1, 32'($urandom), 4'($urandom), 1'($urandom), ST_EXECUTE, 0, 0, 0, 0, 0);
        cyc(d, 1'b1, 32'($urandom), 4'($urandom), 1'($urandom), ST_WRITEBACK, 0, 0, ewe, 1, 0);
        chk_fields(d, ins);
        exp_ret[d]++;
    endtask

    initial begin
        reset        = 1'b1;
        imem_valid_v = '0;
        regw_v       = '0;
        rdata_v      = '0;
        aluc_v       = '0;
        exp_ret[0]   = 0;
        exp_ret[1]   = 0;
        exp_cc       = 0;

        ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SLL, ALU_SRL, ALU_MUL, ALU_XOR};

        tbl[0] = '{0, 32'h002081B3, ALU_ADD, 1'b1, 0, 1, 1'b1};
        tbl[1] = '{0, 32'h0020A1B3, ALU_MUL, 1'b1, 0, 3, 1'b1};
        tbl[2] = '{0, 32'h00000013, ALU_ADD, 1'b0, 0, 1, 1'b0};
        tbl[3] = '{0, 32'h0020C1B3, ALU_XOR, 1'b1, 5, 1, 1'b1};
        tbl[4] = '{0, 32'h0020F1B3, 4'b1111, 1'b1, 1, 1, 1'b1};
        tbl[5] = '{0, 32'h0220A1B3, ALU_MUL, 1'b0, 2, 3, 1'b0};
        tbl[6] = '{1, 32'h0020A1B3, ALU_MUL, 1'b1, 0, 1, 1'b1};
        tbl[7] = '{1, 32'h002081B3, ALU_ADD, 1'b1, 0, 1, 1'b1};
        tbl[8] = '{1, 32'h0020A1B3, ALU_MUL, 1'b0, 3, 1, 1'b0};

        reset_cycle(1'b0, ST_FETCH);
        reset_cycle(1'b1, ST_FETCH);
        cyc(0, 1'b0, 32'h0, ALU_AND, 1'b0, ST_FETCH, 1, 0, 0, 0, 0);
        chk("dut1_reset_state",   32'(state_v[1]),  32'(ST_FETCH));
        chk("dut1_reset_retired", retired_v[1],     32'd0);
        chk("dut1_reset_halted",  32'(halted_v[1]), 32'd0);
        chk_fields(0, 32'h0);

        for (int i = 0; i < 9; i++)
            if (tbl[i].dut == 0)
                run_instr(0, tbl[i].ins, tbl[i].ac, tbl[i].rw, tbl[i].waits, tbl[i].ex, tbl[i].we);

        for (int i = 0; i < 20; i++) begin
            logic [3:0] ac;
            logic       rw;
            ac = ops[$urandom_range(6)];
            rw = 1'($urandom);
            run_instr(0, 32'($urandom), ac, rw, int'($urandom_range(3)), (ac == ALU_MUL) ? 3 : 1, rw);
        end

        // reset in the second MUL cycle aborts the instruction
        cyc(0, 1'b1, 32'h0020A1B3, ALU_MUL, 1'b1, ST_FETCH, 1, 0, 0, 0, 0);
        cyc(0, 1'b0, 32'h0, ALU_MUL, 1'b1, ST_DECODE, 0, 0, 0, 0, 0);
        cyc(0, 1'b0, 32'h0, ALU_MUL, 1'b1, ST_EXECUTE, 0, 1, 0, 0, 0);
        reset_cycle(1'b1, ST_EXECUTE);
        for (int i = 0; i < 4; i++)
            cyc(0, 1'b0, 32'h0, ALU_MUL, 1'b1, ST_FETCH, 1, 0, 0, 0, 0);

        // HCF, then an ADD offered on imem that must never be taken
        run_instr(0, 32'h022081B3, ALU_HCF, 1'b1, 0, 1, 1'b0);
        for (int i = 0; i < 50; i++)
            cyc(0, 1'b1, 32'h002081B3, ALU_ADD, 1'b1, ST_HALT, 0, 0, 0, 0, 1);

        reset_cycle(1'b1, ST_HALT);
        cyc(0, 1'b0, 32'h0, ALU_ADD, 1'b0, ST_FETCH, 1, 0, 0, 0, 0);
        run_instr(0, 32'h002081B3, ALU_ADD, 1'b1, 0, 1, 1'b1);

        for (int i = 0; i < 9; i++)
            if (tbl[i].dut == 1)
                run_instr(1, tbl[i].ins, tbl[i].ac, tbl[i].rw, tbl[i].waits, tbl[i].ex, tbl[i].we);

        for (int i = 0; i < 10; i++) begin
            logic [3:0] ac;
            logic       rw;
            ac = ops[$urandom_range(6)];
            rw = 1'($urandom);
            run_instr(1, 32'($urandom), ac, rw, int'($urandom_range(2)), 1, rw);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
